// File: rtl/pcie_pkg.sv
// Shared encodings for the PCIe/AXI bridge: TLP fmt/type codes, AXI constants and FSM states.
package pcie_pkg;
  localparam logic [2:0] FMT_MWR_3DW    = 3'b010;
  localparam logic [2:0] FMT_MWR_4DW    = 3'b011;
  localparam logic [4:0] TYPE_MEM       = 5'b00000;
  localparam logic [2:0] AXI_SIZE_128   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int         MAX_PAYLOAD_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_XFER,
    ST_RESP
  } wr_state_t;
endpackage

// File: rtl/pcie_tlp_axi_wr_master_if.sv
// AXI write channels (AW/W/B) between the inbound TLP write master and the system fabric.
interface pcie_tlp_axi_wr_master_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
) ();
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [127:0]          wdata;
  logic [15:0]           wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/pcie_wstrb_gen.sv
// Byte strobe for one 16-byte beat: full on every beat except a last beat carrying a partial DW group.
module pcie_wstrb_gen (
  input  logic [1:0]  len_mod,
  input  logic        last,
  output logic [15:0] wstrb
);
  always_comb begin
    wstrb = 16'hFFFF;
    if (last) begin
      case (len_mod)
        2'd1:    wstrb = 16'h000F;
        2'd2:    wstrb = 16'h00FF;
        2'd3:    wstrb = 16'h0FFF;
        default: wstrb = 16'hFFFF;
      endcase
    end
  end
endmodule

// File: rtl/pcie_tlp_axi_wr_master.sv
// Replays one Memory-Write TLP as a single INCR AXI write burst and reports its completion.
// Optional build macro PCIE_RX_ERR_STAT_EN adds saturating drop/B-error counters.
//
// state | meaning
// IDLE  | tlp_ready high, waiting for a TLP
// CHECK | validate latched header, reject or launch burst
// XFER  | AW and W channels run independently
// RESP  | bready high, waiting for the B response
module pcie_tlp_axi_wr_master
  import pcie_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 4,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int WR_ID          = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tlp_valid,
  output logic                      tlp_ready,
  input  logic [2:0]                tlp_fmt,
  input  logic [4:0]                tlp_type,
  input  logic [2:0]                tlp_tc,
  input  logic [8:0]                tlp_length,
  input  logic [15:0]               tlp_req_id,
  input  logic [AXI_ADDR_WIDTH-1:0] tlp_addr,
  input  logic [1023:0]             tlp_data,
  pcie_tlp_axi_wr_master_if.master  axi,
  output logic                      wr_done,
  output logic                      wr_err
`ifdef PCIE_RX_ERR_STAT_EN
  ,
  output logic [15:0]               drop_cnt,
  output logic [15:0]               bresp_err_cnt
`endif
);
  wr_state_t                 state;
  logic [2:0]                fmt_q;
  logic [4:0]                type_q;
  logic [2:0]                tc_q;
  logic [8:0]                len_q;
  logic [15:0]               req_id_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [1023:0]             data_q;
  logic [2:0]                beat_q;
  logic                      aw_done;
  logic                      w_done;

  logic [3:0]   beats;
  logic [2:0]   last_idx;
  logic [2:0]   beat_nxt;
  logic         last_nxt;
  logic [15:0]  strb_nxt;
  logic [127:0] wdata_nxt;
  logic         tlp_ok;
  logic         aw_hs;
  logic         w_hs;
  logic         wl_hs;
  logic         b_ok;
  logic         unused_capt;

  assign beats     = 4'((len_q + 9'd3) >> 2);
  assign last_idx  = 3'(beats - 4'd1);
  assign beat_nxt  = (state == ST_CHECK) ? 3'd0 : beat_q + 3'd1;
  assign last_nxt  = (beat_nxt == last_idx);
  assign wdata_nxt = data_q[{beat_nxt, 7'd0} +: 128];
  assign tlp_ok    = (fmt_q == FMT_MWR_3DW || fmt_q == FMT_MWR_4DW) && (type_q == TYPE_MEM)
                     && (len_q != 9'd0) && (len_q <= 9'(MAX_PAYLOAD_DW)) && (addr_q[3:0] == 4'd0);
  assign aw_hs     = axi.awvalid & axi.awready;
  assign w_hs      = axi.wvalid & axi.wready;
  assign wl_hs     = w_hs & axi.wlast;
  assign b_ok      = (axi.bresp == AXI_RESP_OKAY) && (axi.bid == AXI_ID_WIDTH'(WR_ID));
  // tc and requester ID are kept for debug visibility only
  assign unused_capt = ^{tc_q, req_id_q};

  pcie_wstrb_gen u_wstrb_gen (
    .len_mod (len_q[1:0]),
    .last    (last_nxt),
    .wstrb   (strb_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tlp_ready   <= 1'b0;
      fmt_q       <= '0;
      type_q      <= '0;
      tc_q        <= '0;
      len_q       <= '0;
      req_id_q    <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      beat_q      <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.awid    <= '0;
      axi.awaddr  <= '0;
      axi.awlen   <= '0;
      axi.awsize  <= '0;
      axi.awburst <= '0;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wlast   <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.bready  <= 1'b0;
      wr_done     <= 1'b0;
      wr_err      <= 1'b0;
`ifdef PCIE_RX_ERR_STAT_EN
      drop_cnt      <= '0;
      bresp_err_cnt <= '0;
`endif
    end else begin
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tlp_valid && tlp_ready) begin
            fmt_q     <= tlp_fmt;
            type_q    <= tlp_type;
            tc_q      <= tlp_tc;
            len_q     <= tlp_length;
            req_id_q  <= tlp_req_id;
            addr_q    <= tlp_addr;
            data_q    <= tlp_data;
            tlp_ready <= 1'b0;
            state     <= ST_CHECK;
          end else begin
            tlp_ready <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (tlp_ok) begin
            axi.awid    <= AXI_ID_WIDTH'(WR_ID);
            axi.awaddr  <= addr_q;
            axi.awlen   <= {5'd0, last_idx};
            axi.awsize  <= AXI_SIZE_128;
            axi.awburst <= AXI_BURST_INCR;
            axi.awvalid <= 1'b1;
            axi.wdata   <= wdata_nxt;
            axi.wstrb   <= strb_nxt;
            axi.wlast   <= last_nxt;
            axi.wvalid  <= 1'b1;
            beat_q      <= beat_nxt;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            state       <= ST_XFER;
          end else begin
            wr_err    <= 1'b1;
            tlp_ready <= 1'b1;
            state     <= ST_IDLE;
`ifdef PCIE_RX_ERR_STAT_EN
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
`endif
          end
        end
        ST_XFER: begin
          if (aw_hs) axi.awvalid <= 1'b0;
          if (w_hs) begin
            if (axi.wlast) begin
              axi.wvalid <= 1'b0;
              axi.wlast  <= 1'b0;
            end else begin
              beat_q    <= beat_nxt;
              axi.wdata <= wdata_nxt;
              axi.wstrb <= strb_nxt;
              axi.wlast <= last_nxt;
            end
          end
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | wl_hs;
          // either channel may finish first; leave once both have
          if ((aw_done | aw_hs) && (w_done | wl_hs)) begin
            axi.bready <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (axi.bvalid) begin
            axi.bready <= 1'b0;
            tlp_ready  <= 1'b1;
            state      <= ST_IDLE;
            if (b_ok) begin
              wr_done <= 1'b1;
            end else begin
              wr_err <= 1'b1;
`ifdef PCIE_RX_ERR_STAT_EN
              if (bresp_err_cnt != 16'hFFFF) bresp_err_cnt <= bresp_err_cnt + 16'd1;
`endif
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
